// File: rtl/tt_vpu_ovi_mon_pkg.sv
// Shared types and constants for the OVI protocol monitor.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package tt_vpu_ovi_mon_pkg;

   // Lifecycle of one scoreboard id as seen on the OVI interface.
   typedef enum logic [1:0] {
      SB_IDLE       = 2'd0,
      SB_ISSUED     = 2'd1,
      SB_DISPATCHED = 2'd2
   } sb_state_t;

   // Bit positions in err_vec; the index doubles as the first-error code.
   localparam int ERR_DISP_NO_ISSUE    = 0;
   localparam int ERR_DOUBLE_ISSUE     = 1;
   localparam int ERR_CMPL_NOT_DISP    = 2;
   localparam int ERR_KILL_AND_SENIOR  = 3;
   localparam int ERR_MEMOP_UNDERFLOW  = 4;
   localparam int ERR_MEMOP_OVERFLOW   = 5;
   localparam int ERR_MEMOP_TIMEOUT    = 6;
   localparam int ERR_CREDIT_UNDERFLOW = 7;
   localparam int ERR_CREDIT_OVERFLOW  = 8;
   localparam int NUM_ERR              = 9;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [3:0] first_err_idx(input logic [NUM_ERR-1:0] v);
      first_err_idx = 4'd0;
      for (int i = NUM_ERR - 1; i >= 0; i--) begin
         if (v[i]) first_err_idx = 4'(i);
      end
   endfunction

endpackage

// File: rtl/tt_vpu_ovi_protocol_monitor_if.sv
// OVI issue/dispatch/completion/memop strobes observed by the protocol monitor.
// Latency: n/a (wires only).
// Backpressure: none; the monitor side is input-only.
// Ports (modports): master drives every strobe, slave (the monitor) only reads them.
interface tt_vpu_ovi_protocol_monitor_if #(
   parameter int SB_ID_W = 5
) ();
   logic               issue_valid;
   logic [SB_ID_W-1:0] issue_sb_id;
   logic               issue_credit;
   logic               dispatch_next_senior;
   logic               dispatch_kill;
   logic [SB_ID_W-1:0] dispatch_sb_id;
   logic               completed_valid;
   logic [SB_ID_W-1:0] completed_sb_id;
   logic               memop_sync_start;
   logic               memop_sync_end;

   modport master (
      output issue_valid, issue_sb_id, issue_credit,
             dispatch_next_senior, dispatch_kill, dispatch_sb_id,
             completed_valid, completed_sb_id,
             memop_sync_start, memop_sync_end
   );

   modport slave (
      input  issue_valid, issue_sb_id, issue_credit,
             dispatch_next_senior, dispatch_kill, dispatch_sb_id,
             completed_valid, completed_sb_id,
             memop_sync_start, memop_sync_end
   );
endinterface

// File: rtl/tt_vpu_ovi_sat_counter.sv
// Up/down counter clamped to [0, MAX] that flags attempts to leave the range.
// Latency: cnt updates one cycle after inc/dec; underflow/overflow are same-cycle combinational.
// Backpressure: none; an out-of-range step is dropped and the count holds.
// Ports: clk, reset_n, inc, dec in; cnt, underflow, overflow out.
module tt_vpu_ovi_sat_counter #(
   parameter int W   = 5,
   parameter int MAX = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         underflow,
   output logic         overflow
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] cnt_q;

   // inc and dec together cancel, so only a lone step can leave the range.
   assign underflow = dec && !inc && (cnt_q == '0);
   assign overflow  = inc && !dec && (cnt_q == MAX_V);
   assign cnt       = cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (inc && !dec && !overflow) begin
         cnt_q <= cnt_q + W'(1);
      end else if (dec && !inc && !underflow) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

endmodule

// File: rtl/tt_vpu_ovi_protocol_monitor.sv
// OVI protocol monitor: per-sb-id lifecycle, issue credits, memop windows, sticky errors.
// Latency: a violation in cycle N shows in err_vec/err_valid/first_err_* in cycle N+1.
// Backpressure: none; pure observer, all interface signals are inputs.
// Ports: clk, reset_n; ovi (slave modport) carries the OVI strobes; err_clear in;
//        err_vec, err_valid, first_err_code, first_err_sb_id, inflight_cnt,
//        memop_pending, credits out.
// Build option: define TT_OVI_MON_SVA_EN to add concurrent assertions (one per error
// bit plus eventual memop drain); registers are identical with or without it.
module tt_vpu_ovi_protocol_monitor
   import tt_vpu_ovi_mon_pkg::*;
#(
   parameter int SB_ID_W       = 5,
   parameter int MAX_CREDITS   = 16,
   parameter int MEMOP_CNT_W   = 6,
   parameter int TIMEOUT_W     = 16,
   parameter int MEMOP_TIMEOUT = 4096
) (
   input  logic                               clk,
   input  logic                               reset_n,
   tt_vpu_ovi_protocol_monitor_if.slave       ovi,
   input  logic                               err_clear,
   output logic [NUM_ERR-1:0]                 err_vec,
   output logic                               err_valid,
   output logic [3:0]                         first_err_code,
   output logic [SB_ID_W-1:0]                 first_err_sb_id,
   output logic [SB_ID_W:0]                   inflight_cnt,
   output logic [MEMOP_CNT_W-1:0]             memop_pending,
   output logic [$clog2(MAX_CREDITS+1)-1:0]   credits
);

   localparam int NUM_SB = 1 << SB_ID_W;
   localparam int CNT_W  = SB_ID_W + 1;
   localparam int CRD_W  = $clog2(MAX_CREDITS + 1);
   localparam logic [TIMEOUT_W-1:0] TMO_MAX  = TIMEOUT_W'(MEMOP_TIMEOUT);
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(MEMOP_TIMEOUT - 1);

   // ---------------------------------------------------------------- sb FSMs
   sb_state_t sb_q   [NUM_SB];
   sb_state_t sb_nxt [NUM_SB];

   logic [NUM_SB-1:0] iss_hit, sen_hit, kill_hit, cmpl_hit;
   logic [CNT_W-1:0]  inflight_nxt;

   always_comb begin
      for (int i = 0; i < NUM_SB; i++) begin
         iss_hit[i]  = ovi.issue_valid && (ovi.issue_sb_id == SB_ID_W'(i));
         sen_hit[i]  = ovi.dispatch_next_senior && (ovi.dispatch_sb_id == SB_ID_W'(i));
         // next_senior outranks a simultaneous kill
         kill_hit[i] = ovi.dispatch_kill && !ovi.dispatch_next_senior &&
                       (ovi.dispatch_sb_id == SB_ID_W'(i));
         cmpl_hit[i] = ovi.completed_valid && (ovi.completed_sb_id == SB_ID_W'(i));
      end
   end

   // Illegal strobes are flagged elsewhere; here they simply leave the entry alone
   // so tracking continues on the legal part of the traffic.
   always_comb begin
      inflight_nxt = '0;
      for (int i = 0; i < NUM_SB; i++) begin
         sb_nxt[i] = sb_q[i];
         unique case (sb_q[i])
            SB_IDLE: begin
               if (iss_hit[i]) begin
                  if (sen_hit[i])       sb_nxt[i] = SB_DISPATCHED;
                  else if (kill_hit[i]) sb_nxt[i] = SB_IDLE;
                  else                  sb_nxt[i] = SB_ISSUED;
               end
            end
            SB_ISSUED: begin
               if (sen_hit[i])       sb_nxt[i] = SB_DISPATCHED;
               else if (kill_hit[i]) sb_nxt[i] = SB_IDLE;
            end
            SB_DISPATCHED: begin
               if (cmpl_hit[i]) sb_nxt[i] = SB_IDLE;
            end
            default: sb_nxt[i] = SB_IDLE;
         endcase
         inflight_nxt = inflight_nxt + CNT_W'(sb_nxt[i] != SB_IDLE);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SB; i++) sb_q[i] <= SB_IDLE;
      end else begin
         for (int i = 0; i < NUM_SB; i++) sb_q[i] <= sb_nxt[i];
      end
   end

   // ---------------------------------------------------------------- counters
   logic crd_unf, crd_ovf, mem_unf, mem_ovf;

   tt_vpu_ovi_sat_counter #(
      .W   (CRD_W),
      .MAX (MAX_CREDITS)
   ) u_credit_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (ovi.issue_credit),
      .dec       (ovi.issue_valid),
      .cnt       (credits),
      .underflow (crd_unf),
      .overflow  (crd_ovf)
   );

   tt_vpu_ovi_sat_counter #(
      .W   (MEMOP_CNT_W),
      .MAX ((1 << MEMOP_CNT_W) - 1)
   ) u_memop_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (ovi.memop_sync_start),
      .dec       (ovi.memop_sync_end),
      .cnt       (memop_pending),
      .underflow (mem_unf),
      .overflow  (mem_ovf)
   );

   // ---------------------------------------------------------------- watchdog
   logic [TIMEOUT_W-1:0] wd_timer;
   logic                 wd_hit;

   // Fires only on the step into the saturated value, so the bit sets once per stall.
   assign wd_hit = (memop_pending != '0) && !ovi.memop_sync_end && (wd_timer == TMO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_timer <= '0;
      end else if ((memop_pending == '0) || ovi.memop_sync_end) begin
         wd_timer <= '0;
      end else if (wd_timer != TMO_MAX) begin
         wd_timer <= wd_timer + TIMEOUT_W'(1);
      end
   end

   // ---------------------------------------------------------------- error detect
   logic [NUM_ERR-1:0] err_now;
   logic               iss_eq_disp, iss_eq_cmpl;
   sb_state_t          st_iss, st_disp, st_cmpl;

   assign st_iss      = sb_q[ovi.issue_sb_id];
   assign st_disp     = sb_q[ovi.dispatch_sb_id];
   assign st_cmpl     = sb_q[ovi.completed_sb_id];
   assign iss_eq_disp = ovi.issue_valid && (ovi.issue_sb_id == ovi.dispatch_sb_id);
   assign iss_eq_cmpl = ovi.issue_valid && (ovi.issue_sb_id == ovi.completed_sb_id);

   always_comb begin
      err_now = '0;
      err_now[ERR_DISP_NO_ISSUE]    = (ovi.dispatch_next_senior || ovi.dispatch_kill) &&
                                      (st_disp == SB_IDLE) && !iss_eq_disp;
      err_now[ERR_DOUBLE_ISSUE]     = ovi.issue_valid && (st_iss != SB_IDLE);
      err_now[ERR_CMPL_NOT_DISP]    = ovi.completed_valid &&
                                      ((st_cmpl != SB_DISPATCHED) || iss_eq_cmpl);
      err_now[ERR_KILL_AND_SENIOR]  = ovi.dispatch_next_senior && ovi.dispatch_kill;
      err_now[ERR_MEMOP_UNDERFLOW]  = mem_unf;
      err_now[ERR_MEMOP_OVERFLOW]   = mem_ovf;
      err_now[ERR_MEMOP_TIMEOUT]    = wd_hit;
      err_now[ERR_CREDIT_UNDERFLOW] = crd_unf;
      err_now[ERR_CREDIT_OVERFLOW]  = crd_ovf;
   end

   // Id tied to the lowest-index error this cycle; non-id errors report 0.
   logic [SB_ID_W-1:0] err_id_now;

   always_comb begin
      err_id_now = '0;
      if (err_now[ERR_DISP_NO_ISSUE])        err_id_now = ovi.dispatch_sb_id;
      else if (err_now[ERR_DOUBLE_ISSUE])    err_id_now = ovi.issue_sb_id;
      else if (err_now[ERR_CMPL_NOT_DISP])   err_id_now = ovi.completed_sb_id;
      else if (err_now[ERR_KILL_AND_SENIOR]) err_id_now = ovi.dispatch_sb_id;
   end

   // ---------------------------------------------------------------- sticky errors
   // A clear empties the base first, so an error in the clear cycle is both
   // "new" for err_valid and eligible for first-error capture.
   logic [NUM_ERR-1:0] err_base;

   assign err_base = err_clear ? '0 : err_vec;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_vec         <= '0;
         err_valid       <= 1'b0;
         first_err_code  <= '0;
         first_err_sb_id <= '0;
         inflight_cnt    <= '0;
      end else begin
         err_vec      <= err_base | err_now;
         err_valid    <= |(err_now & ~err_base);
         inflight_cnt <= inflight_nxt;
         if ((err_base == '0) && (err_now != '0)) begin
            first_err_code  <= first_err_idx(err_now);
            first_err_sb_id <= err_id_now;
         end else if (err_clear) begin
            first_err_code  <= '0;
            first_err_sb_id <= '0;
         end
      end
   end

`ifdef TT_OVI_MON_SVA_EN
   for (genvar g = 0; g < NUM_ERR; g++) begin : g_err_sva
      a_no_err : assert property (@(posedge clk) disable iff (!reset_n) !err_now[g]);
   end

   a_memop_drains : assert property (@(posedge clk) disable iff (!reset_n)
      (memop_pending != '0) |-> s_eventually (memop_pending == '0));
`else
`endif

endmodule

// File: tb/tb_tt_vpu_ovi_protocol_monitor.sv
// Directed bench for the OVI protocol monitor; expected values are hand-derived constants.
// Latency: inputs applied 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: n/a.
module tb_tt_vpu_ovi_protocol_monitor;
   import tt_vpu_ovi_mon_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        err_clear;
   logic [8:0]  err_vec;
   logic        err_valid;
   logic [3:0]  first_err_code;
   logic [4:0]  first_err_sb_id;
   logic [5:0]  inflight_cnt;
   logic [5:0]  memop_pending;
   logic [4:0]  credits;

   int n_vec = 0;
   int n_err = 0;

   tt_vpu_ovi_protocol_monitor_if #(.SB_ID_W(5)) ovi ();

   tt_vpu_ovi_protocol_monitor dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .ovi             (ovi),
      .err_clear       (err_clear),
      .err_vec         (err_vec),
      .err_valid       (err_valid),
      .first_err_code  (first_err_code),
      .first_err_sb_id (first_err_sb_id),
      .inflight_cnt    (inflight_cnt),
      .memop_pending   (memop_pending),
      .credits         (credits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      ovi.issue_valid          = 1'b0;
      ovi.issue_sb_id          = '0;
      ovi.issue_credit         = 1'b0;
      ovi.dispatch_next_senior = 1'b0;
      ovi.dispatch_kill        = 1'b0;
      ovi.dispatch_sb_id       = '0;
      ovi.completed_valid      = 1'b0;
      ovi.completed_sb_id      = '0;
      ovi.memop_sync_start     = 1'b0;
      ovi.memop_sync_end       = 1'b0;
      err_clear                = 1'b0;
   endtask

   // One clock with the currently driven inputs, then back to idle.
   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   // Issue with a returned credit so the credit count stays neutral.
   task automatic do_issue(input logic [4:0] id);
      ovi.issue_valid = 1'b1; ovi.issue_sb_id = id; ovi.issue_credit = 1'b1;
      step();
   endtask

   task automatic do_kill(input logic [4:0] id);
      ovi.dispatch_kill = 1'b1; ovi.dispatch_sb_id = id;
      step();
   endtask

   task automatic do_clear();
      err_clear = 1'b1;
      step();
   endtask

   initial begin
      reset_n = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_err_vec",   32'(err_vec), 0);
      chk("rst_err_valid", 32'(err_valid), 0);
      chk("rst_code",      32'(first_err_code), 0);
      chk("rst_inflight",  32'(inflight_cnt), 0);
      chk("rst_memop",     32'(memop_pending), 0);
      chk("rst_credits",   32'(credits), 0);
      reset_n = 1'b1;

      // Clean lifecycle of id 3 with one credit returned up front.
      ovi.issue_credit = 1'b1; step();
      chk("t1_credit", 32'(credits), 1);
      ovi.issue_valid = 1'b1; ovi.issue_sb_id = 5'd3; step();
      chk("t1_inflight_iss", 32'(inflight_cnt), 1);
      chk("t1_credit_used",  32'(credits), 0);
      ovi.dispatch_next_senior = 1'b1; ovi.dispatch_sb_id = 5'd3; step();
      chk("t1_inflight_disp", 32'(inflight_cnt), 1);
      ovi.completed_valid = 1'b1; ovi.completed_sb_id = 5'd3; step();
      chk("t1_inflight_cmpl", 32'(inflight_cnt), 0);
      chk("t1_err_vec",       32'(err_vec), 0);

      // Double issue of id 7.
      do_issue(5'd7);
      chk("t2_first_ok", 32'(err_vec), 0);
      do_issue(5'd7);
      chk("t2_err_vec", 32'(err_vec), 32'h002);
      chk("t2_valid",   32'(err_valid), 1);
      chk("t2_code",    32'(first_err_code), 1);
      chk("t2_sb_id",   32'(first_err_sb_id), 7);
      step();
      chk("t2_valid_once", 32'(err_valid), 0);
      chk("t2_sticky",     32'(err_vec), 32'h002);
      chk("t2_inflight",   32'(inflight_cnt), 1);
      do_clear();
      chk("t2_clr_vec",  32'(err_vec), 0);
      chk("t2_clr_code", 32'(first_err_code), 0);
      chk("t2_clr_id",   32'(first_err_sb_id), 0);
      do_kill(5'd7);
      chk("t2_kill_inflight", 32'(inflight_cnt), 0);
      chk("t2_kill_ok",       32'(err_vec), 0);

      // Kill + next_senior on idle id 5.
      ovi.dispatch_kill = 1'b1; ovi.dispatch_next_senior = 1'b1; ovi.dispatch_sb_id = 5'd5;
      step();
      chk("t3_err_vec", 32'(err_vec), 32'h009);
      chk("t3_code",    32'(first_err_code), 0);
      chk("t3_sb_id",   32'(first_err_sb_id), 5);
      chk("t3_inflight", 32'(inflight_cnt), 0);
      do_clear();

      // Same-cycle combinations.
      ovi.dispatch_next_senior = 1'b1; ovi.dispatch_sb_id = 5'd20; do_issue(5'd20);
      chk("sc_iss_sen_inflight", 32'(inflight_cnt), 1);
      chk("sc_iss_sen_err",      32'(err_vec), 0);
      ovi.completed_valid = 1'b1; ovi.completed_sb_id = 5'd20; step();
      chk("sc_cmpl_inflight", 32'(inflight_cnt), 0);
      ovi.dispatch_kill = 1'b1; ovi.dispatch_sb_id = 5'd21; do_issue(5'd21);
      chk("sc_iss_kill_inflight", 32'(inflight_cnt), 0);
      chk("sc_iss_kill_err",      32'(err_vec), 0);
      ovi.completed_valid = 1'b1; ovi.completed_sb_id = 5'd22; do_issue(5'd22);
      chk("sc_iss_cmpl_err",  32'(err_vec), 32'h004);
      chk("sc_iss_cmpl_code", 32'(first_err_code), 2);
      chk("sc_iss_cmpl_id",   32'(first_err_sb_id), 22);
      chk("sc_iss_cmpl_inflight", 32'(inflight_cnt), 1);
      do_clear();
      do_kill(5'd22);

      // Memop underflow, then a clear racing a fresh error.
      ovi.memop_sync_end = 1'b1; step();
      chk("mu_err_vec", 32'(err_vec), 32'h010);
      chk("mu_pending", 32'(memop_pending), 0);
      chk("mu_code",    32'(first_err_code), 4);
      err_clear = 1'b1; ovi.memop_sync_end = 1'b1; step();
      chk("clr_race_vec",   32'(err_vec), 32'h010);
      chk("clr_race_valid", 32'(err_valid), 1);
      chk("clr_race_code",  32'(first_err_code), 4);
      do_clear();
      chk("mu_clr_vec", 32'(err_vec), 0);

      // Credit underflow and overflow.
      ovi.issue_valid = 1'b1; ovi.issue_sb_id = 5'd9; step();
      chk("cu_err_vec", 32'(err_vec), 32'h080);
      chk("cu_credits", 32'(credits), 0);
      chk("cu_code",    32'(first_err_code), 7);
      chk("cu_id",      32'(first_err_sb_id), 0);
      do_clear();
      do_kill(5'd9);
      repeat (16) begin
         ovi.issue_credit = 1'b1; step();
      end
      chk("co_full",     32'(credits), 16);
      chk("co_full_err", 32'(err_vec), 0);
      ovi.issue_credit = 1'b1; step();
      chk("co_err_vec", 32'(err_vec), 32'h100);
      chk("co_credits", 32'(credits), 16);
      do_clear();

      // Watchdog: one memop left pending with no end.
      ovi.memop_sync_start = 1'b1; step();
      chk("wd_pending", 32'(memop_pending), 1);
      repeat (4095) step();
      chk("wd_before", 32'(err_vec), 0);
      step();
      chk("wd_err_vec", 32'(err_vec), 32'h040);
      chk("wd_valid",   32'(err_valid), 1);
      chk("wd_code",    32'(first_err_code), 6);
      step();
      chk("wd_valid_once", 32'(err_valid), 0);
      ovi.memop_sync_end = 1'b1; step();
      chk("wd_drain",   32'(memop_pending), 0);
      chk("wd_cleared", 32'(dut.wd_timer), 0);
      do_clear();

      // Memop overflow at all-ones.
      repeat (63) begin
         ovi.memop_sync_start = 1'b1; step();
      end
      chk("mo_full",     32'(memop_pending), 63);
      chk("mo_full_err", 32'(err_vec), 0);
      ovi.memop_sync_start = 1'b1; step();
      chk("mo_err_vec", 32'(err_vec), 32'h020);
      chk("mo_pending", 32'(memop_pending), 63);
      do_clear();
      repeat (61) begin
         ovi.memop_sync_end = 1'b1; step();
      end
      chk("mo_drain2", 32'(memop_pending), 2);

      // Mid-operation reset with 4 ids in flight.
      do_issue(5'd4); do_issue(5'd10); do_issue(5'd11); do_issue(5'd12);
      chk("rr_inflight", 32'(inflight_cnt), 4);
      chk("rr_clean",    32'(err_vec), 0);
      reset_n = 1'b0;
      #2;
      chk("rr_inflight0", 32'(inflight_cnt), 0);
      chk("rr_pending0",  32'(memop_pending), 0);
      chk("rr_credits0",  32'(credits), 0);
      chk("rr_err0",      32'(err_vec), 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      do_issue(5'd4);
      chk("rr_reissue_err",      32'(err_vec), 0);
      chk("rr_reissue_inflight", 32'(inflight_cnt), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
